// File: rtl/next_pc_predictor.sv
// Fetch PC register with a direct-mapped BTB and 2-bit counters for next-PC prediction.
// Latency: prediction is combinational on pc; redirect lands on pc one edge after flush.
// Backpressure: stall holds pc, but a misprediction redirect always takes priority over stall.
module next_pc_predictor #(
  parameter int              XLEN         = 32,
  parameter int              BTB_DEPTH    = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            flush
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BTB_DEPTH-1:0] valid;
  logic [1:0]           ctr     [BTB_DEPTH];
  logic [TAG_W-1:0]     tag_mem [BTB_DEPTH];
  logic [XLEN-1:0]      tgt     [BTB_DEPTH];

  logic [IDX_W-1:0] idx, u_idx;
  logic [TAG_W-1:0] tag, u_tag;
  logic             hit, u_hit, btb_upd;
  logic [XLEN-1:0]  redirect_pc;

  assign idx   = pc[IDX_W+1:2];
  assign tag   = pc[XLEN-1:IDX_W+2];
  assign u_idx = ex_pc[IDX_W+1:2];
  assign u_tag = ex_pc[XLEN-1:IDX_W+2];

  assign hit   = valid[idx] && (tag_mem[idx] == tag);
  assign u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);

  always_comb begin
    pred_taken  = hit && ctr[idx][1];
    pred_target = pc + XLEN'(4);
    if (pred_taken) pred_target = tgt[idx];
  end

  assign flush = ex_valid && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_target != ex_pred_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + XLEN'(4);

  // JALR targets are register-dependent, so they never enter the BTB.
  assign btb_upd = ex_valid && (ex_is_branch || ex_is_jal) && !ex_is_jalr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_VECTOR;
      valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) ctr[i] <= 2'b01;
    end else begin
      if (flush)       pc <= redirect_pc;
      else if (!stall) pc <= pred_target;

      if (btb_upd) begin
        if (u_hit) begin
          if (ex_taken) begin
            if (ctr[u_idx] != 2'b11) ctr[u_idx] <= ctr[u_idx] + 2'd1;
          end else if (ctr[u_idx] != 2'b00) begin
            ctr[u_idx] <= ctr[u_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          valid[u_idx] <= 1'b1;
          ctr[u_idx]   <= 2'b10;
        end
      end
    end
  end

  // Tag and target carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (btb_upd && ex_taken) begin
      tag_mem[u_idx] <= u_tag;
      tgt[u_idx]     <= ex_target;
    end
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed-vector bench for next_pc_predictor (XLEN=32, BTB_DEPTH=64, RESET_VECTOR=0).
module tb_next_pc_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] NONE = 3'b000, BR = 3'b100, JAL = 3'b010, JALR = 3'b001;

  typedef struct {
    logic        stall;
    logic        v;
    logic [2:0]  typ;
    logic [31:0] expc;
    logic        tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_fl;
    logic [31:0] e_next;
  } vec_t;

  vec_t vecs[$];

  next_pc_predictor #(.XLEN(32), .BTB_DEPTH(64), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_taken(ex_taken),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=0x%08h want=0x%08h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic v, input logic [2:0] typ, input logic [31:0] expc,
                     input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_ptgt,
                     input logic e_fl, input logic [31:0] e_next);
    vec_t r;
    r.stall = s; r.v = v; r.typ = typ; r.expc = expc; r.tk = tk; r.tgt = tgt;
    r.ptk = ptk; r.ptgt = ptgt; r.e_pc = e_pc; r.e_pt = e_pt; r.e_ptgt = e_ptgt;
    r.e_fl = e_fl; r.e_next = e_next;
    vecs.push_back(r);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; ex_valid = 1'b0; ex_pc = '0;
    {ex_is_branch, ex_is_jal, ex_is_jalr} = NONE;
    ex_taken = 1'b0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  initial begin
    // idle fetch from reset
    add(0,0,NONE,0,0,0,0,0,              32'h0,   0,32'h4,  0,32'h4);
    add(0,0,NONE,0,0,0,0,0,              32'h4,   0,32'h8,  0,32'h8);
    add(0,0,NONE,0,0,0,0,0,              32'h8,   0,32'hC,  0,32'hC);
    add(0,0,NONE,0,0,0,0,0,              32'hC,   0,32'h10, 0,32'h10);
    // branch 0x10 -> 0x0 mispredicted: allocate ctr=10, lookup still misses this cycle
    add(0,1,BR,32'h10,1,32'h0,0,32'h14,  32'h10,  0,32'h14, 1,32'h0);
    add(0,0,NONE,0,0,0,0,0,              32'h0,   0,32'h4,  0,32'h4);
    add(0,0,NONE,0,0,0,0,0,              32'h4,   0,32'h8,  0,32'h8);
    add(0,0,NONE,0,0,0,0,0,              32'h8,   0,32'hC,  0,32'hC);
    add(0,0,NONE,0,0,0,0,0,              32'hC,   0,32'h10, 0,32'h10);
    // predicted taken now; three correct taken resolves saturate to 11
    add(0,1,BR,32'h10,1,32'h0,1,32'h0,   32'h10,  1,32'h0,  0,32'h0);
    add(0,1,BR,32'h10,1,32'h0,1,32'h0,   32'h0,   0,32'h4,  0,32'h4);
    add(0,1,BR,32'h10,1,32'h0,1,32'h0,   32'h4,   0,32'h8,  0,32'h8);
    // first not-taken: flush to 0x14, ctr 11->10
    add(0,1,BR,32'h10,0,32'h0,1,32'h0,   32'h8,   0,32'hC,  1,32'h14);
    add(0,1,JALR,32'h30,1,32'h10,0,32'h34, 32'h14,0,32'h18, 1,32'h10);
    // still taken at ctr=10; second not-taken drops to 01 (lookup sees pre-edge state)
    add(0,1,BR,32'h10,0,32'h0,1,32'h0,   32'h10,  1,32'h0,  1,32'h14);
    add(0,1,JALR,32'h30,1,32'h10,0,32'h34, 32'h14,0,32'h18, 1,32'h10);
    add(0,0,NONE,0,0,0,0,0,              32'h10,  0,32'h14, 0,32'h14);
    // re-train to 10, then alias check at 0x110
    add(0,1,BR,32'h10,1,32'h0,1,32'h0,   32'h14,  0,32'h18, 0,32'h18);
    add(0,1,JALR,32'h50,1,32'h110,0,32'h54, 32'h18,0,32'h1C,1,32'h110);
    add(0,1,JALR,32'h50,1,32'h10,0,32'h54,  32'h110,0,32'h114,1,32'h10);
    add(0,0,NONE,0,0,0,0,0,              32'h10,  1,32'h0,  0,32'h0);
    // JALR 0x40 -> 0x80 always flushes, never allocates
    add(0,1,JALR,32'h40,1,32'h80,0,32'h44, 32'h0, 0,32'h4,  1,32'h80);
    add(0,1,JALR,32'h40,1,32'h80,0,32'h44, 32'h80,0,32'h84, 1,32'h80);
    add(0,1,JALR,32'h60,1,32'h40,0,32'h64, 32'h80,0,32'h84, 1,32'h40);
    add(0,0,NONE,0,0,0,0,0,              32'h40,  0,32'h44, 0,32'h44);
    // untyped resolve flushes but does not allocate
    add(0,1,NONE,32'h44,1,32'h300,0,32'h48, 32'h44,0,32'h48,1,32'h300);
    add(0,1,JALR,32'h60,1,32'h44,0,32'h64,  32'h300,0,32'h304,1,32'h44);
    add(0,0,NONE,0,0,0,0,0,              32'h44,  0,32'h48, 0,32'h48);
    // not-taken miss leaves BTB alone
    add(0,1,BR,32'h48,0,32'h0,0,32'h4C,  32'h48,  0,32'h4C, 0,32'h4C);
    add(0,1,JALR,32'h60,1,32'h48,0,32'h64, 32'h4C,0,32'h50, 1,32'h48);
    add(0,0,NONE,0,0,0,0,0,              32'h48,  0,32'h4C, 0,32'h4C);
    // right direction, wrong target: flush and retarget
    add(0,1,JAL,32'h10,1,32'h20,1,32'h0, 32'h4C,  0,32'h50, 1,32'h20);
    add(0,1,JALR,32'h60,1,32'h10,0,32'h64, 32'h20,0,32'h24, 1,32'h10);
    add(0,0,NONE,0,0,0,0,0,              32'h10,  1,32'h20, 0,32'h20);
    // redirect beats stall, then stall holds
    add(1,1,JALR,32'h60,1,32'h200,0,32'h64, 32'h20,0,32'h24,1,32'h200);
    add(1,0,NONE,0,0,0,0,0,              32'h200, 0,32'h204,0,32'h200);
    add(1,0,NONE,0,0,0,0,0,              32'h200, 0,32'h204,0,32'h200);
    add(1,0,NONE,0,0,0,0,0,              32'h200, 0,32'h204,0,32'h200);
    add(0,0,NONE,0,0,0,0,0,              32'h200, 0,32'h204,0,32'h204);
    // pc+4 wraps at the top of the address space
    add(0,1,JALR,32'h60,1,32'hFFFFFFFC,0,32'h64, 32'h204,0,32'h208,1,32'hFFFFFFFC);
    add(0,0,NONE,0,0,0,0,0,              32'hFFFFFFFC,0,32'h0,0,32'h0);

    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset_pc", -1, pc, 32'h0);
    chk("reset_pred_taken", -1, {31'b0, pred_taken}, 32'h0);
    chk("reset_pred_target", -1, pred_target, 32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stall          = vecs[i].stall;
      ex_valid       = vecs[i].v;
      ex_pc          = vecs[i].expc;
      {ex_is_branch, ex_is_jal, ex_is_jalr} = vecs[i].typ;
      ex_taken       = vecs[i].tk;
      ex_target      = vecs[i].tgt;
      ex_pred_taken  = vecs[i].ptk;
      ex_pred_target = vecs[i].ptgt;
      #1;
      chk("pc", i, pc, vecs[i].e_pc);
      chk("pred_taken", i, {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
      chk("pred_target", i, pred_target, vecs[i].e_ptgt);
      chk("flush", i, {31'b0, flush}, {31'b0, vecs[i].e_fl});
      @(posedge clk);
      #1;
      chk("next_pc", i, pc, vecs[i].e_next);
    end

    // asynchronous reset mid-run: pc clears without an edge, BTB is invalidated
    idle_inputs();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pc", -2, pc, 32'h0);
    chk("midrst_pred_taken", -2, {31'b0, pred_taken}, 32'h0);
    chk("midrst_pred_target", -2, pred_target, 32'h4);
    @(posedge clk);
    #1;
    chk("midrst_hold_pc", -2, pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("post_rst_pc", k, pc, 32'(k * 4));
      chk("post_rst_pred_taken", k, {31'b0, pred_taken}, 32'h0);
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
